// File: rtl/fixed_point_divider.sv
// Sign-magnitude fixed-point divider (Qq_m.q_n), restoring algorithm,
// one quotient bit per clock, MSB first. Saturates on overflow and on
// divide-by-zero, with a separate flag for each case.
module fixed_point_divider #(
    parameter int sign = 1,
    parameter int q_m  = 15,
    parameter int q_n  = 16,
    localparam int W   = sign + q_m + q_n,
    localparam int M   = W - 1,
    localparam int N   = M + q_n
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         start_in,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] y_out,
    output logic         valid_out,
    output logic         busy_out,
    output logic         div_by_zero_out,
    output logic         overflow_out
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [N-1:0]    dvd;      // dividend shifts out the top, quotient shifts in the bottom
    logic [M-1:0]    rem;
    logic [M-1:0]    dvs;
    logic            sgn;
    logic            dbz;
    logic [M:0]      trial;
    logic [M:0]      diff;
    logic            q_bit;
    logic [M-1:0]    rem_nxt;

    // Restoring step: bring down the next dividend bit and try a subtract
    always_comb begin
        trial   = {rem, dvd[N-1]};
        diff    = trial - {1'b0, dvs};
        q_bit   = (trial >= {1'b0, dvs});
        rem_nxt = q_bit ? diff[M-1:0] : trial[M-1:0];
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_nxt = (b_in[M-1:0] == '0) ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (count == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Busy whenever an operation is in flight
    always_comb begin
        busy_out = (state != IDLE);
    end

    // Datapath: capture operands, iterate, and register the result in DONE
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            y_out           <= '0;
            valid_out       <= 1'b0;
            div_by_zero_out <= 1'b0;
            overflow_out    <= 1'b0;
            count           <= '0;
            dvd             <= '0;
            rem             <= '0;
            dvs             <= '0;
            sgn             <= 1'b0;
            dbz             <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        dvd   <= {a_in[M-1:0], {q_n{1'b0}}};
                        rem   <= '0;
                        dvs   <= b_in[M-1:0];
                        sgn   <= a_in[W-1] ^ b_in[W-1];
                        dbz   <= (b_in[M-1:0] == '0);
                        count <= CW'(N - 1);
                    end
                end
                DIVIDE: begin
                    dvd <= {dvd[N-2:0], q_bit};
                    rem <= rem_nxt;
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end
                end
                DONE: begin
                    valid_out <= 1'b1;
                    if (dbz) begin
                        y_out           <= {sgn, {M{1'b1}}};
                        div_by_zero_out <= 1'b1;
                        overflow_out    <= 1'b0;
                    end else if (|dvd[N-1:M]) begin
                        y_out           <= {sgn, {M{1'b1}}};
                        div_by_zero_out <= 1'b0;
                        overflow_out    <= 1'b1;
                    end else begin
                        y_out           <= {sgn, dvd[M-1:0]};
                        div_by_zero_out <= 1'b0;
                        overflow_out    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider at default parameters.
module tb_fixed_point_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         valid;
    logic         busy;
    logic         dbz;
    logic         ovf;

    int unsigned  n_cmp  = 0;
    int unsigned  n_fail = 0;
    int unsigned  pulses;

    fixed_point_divider #(.sign(1), .q_m(15), .q_n(16)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .start_in        (start),
        .a_in            (a),
        .b_in            (b),
        .y_out           (y),
        .valid_out       (valid),
        .busy_out        (busy),
        .div_by_zero_out (dbz),
        .overflow_out    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start for one edge (edge 0), then scramble the operand inputs
    task automatic launch(input logic [31:0] na, input logic [31:0] nb);
        a     = na;
        b     = nb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'h7FFF_FFFF;
        b     = 32'h0000_0001;
    endtask

    // Follow one operation edge by edge from edge 1 up to edge lat+1
    task automatic track(input string tag, input logic [31:0] ey, input logic edbz,
                         input logic eovf, input int unsigned lat, input bit ign,
                         input bit chain, input logic [31:0] ca, input logic [31:0] cb);
        for (int unsigned k = 1; k <= lat + 1; k++) begin
            @(posedge clk);
            #1;
            check({tag, "/valid"}, {31'b0, valid}, (k == lat) ? 32'd1 : 32'd0);
            check({tag, "/busy"}, {31'b0, busy},
                  ((k < lat) || (chain && k == lat + 1)) ? 32'd1 : 32'd0);
            if (k >= lat) begin
                check({tag, "/y"}, y, ey);
                check({tag, "/dbz"}, {31'b0, dbz}, {31'b0, edbz});
                check({tag, "/ovf"}, {31'b0, ovf}, {31'b0, eovf});
            end
            if (ign && (k == 9 || k == 29)) begin
                start = 1'b1;
                a     = 32'h0001_0000;
                b     = 32'h0001_0000;
            end
            if (ign && (k == 10 || k == 30)) start = 1'b0;
            if (chain && k == lat) begin
                a     = ca;
                b     = cb;
                start = 1'b1;
            end
            if (chain && k == lat + 1) begin
                start = 1'b0;
                a     = 32'h7FFF_FFFF;
                b     = 32'h0000_0001;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        a     = 32'h0006_0000;
        b     = 32'h0002_0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst/y", y, 32'h0);
        check("rst/valid", {31'b0, valid}, 32'd0);
        check("rst/busy", {31'b0, busy}, 32'd0);
        check("rst/dbz", {31'b0, dbz}, 32'd0);
        check("rst/ovf", {31'b0, ovf}, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;

        launch(32'h0006_0000, 32'h0002_0000);
        track("6div2", 32'h0003_0000, 1'b0, 1'b0, 48, 0, 0, '0, '0);

        launch(32'h8001_8000, 32'h0000_8000);
        track("m1p5div0p5", 32'h8003_0000, 1'b0, 1'b0, 48, 0, 0, '0, '0);

        launch(32'h0001_0000, 32'h0003_0000);
        track("1div3", 32'h0000_5555, 1'b0, 1'b0, 48, 0, 0, '0, '0);

        launch(32'h0001_0000, 32'h8000_0000);
        track("div_negzero", 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 0, 0, '0, '0);

        launch(32'h8001_0000, 32'h0000_0000);
        track("div_poszero", 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 0, 0, '0, '0);

        launch(32'h7FFF_0000, 32'h0000_0001);
        track("overflow", 32'h7FFF_FFFF, 1'b0, 1'b1, 48, 0, 0, '0, '0);

        launch(32'h8000_0000, 32'h0001_0000);
        track("negzero_num", 32'h8000_0000, 1'b0, 1'b0, 48, 0, 0, '0, '0);

        launch(32'h0006_0000, 32'h0002_0000);
        track("ignored_start", 32'h0003_0000, 1'b0, 1'b0, 48, 1, 0, '0, '0);

        launch(32'h0001_0000, 32'h0003_0000);
        track("b2b_first", 32'h0000_5555, 1'b0, 1'b0, 48, 0, 1, 32'h8006_0000, 32'h0002_0000);
        track("b2b_second", 32'h8003_0000, 1'b0, 1'b0, 48, 0, 0, '0, '0);

        // Abort a division at edge 20
        launch(32'h0006_0000, 32'h0002_0000);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort/y", y, 32'h0);
        check("abort/valid", {31'b0, valid}, 32'd0);
        check("abort/busy", {31'b0, busy}, 32'd0);
        check("abort/dbz", {31'b0, dbz}, 32'd0);
        check("abort/ovf", {31'b0, ovf}, 32'd0);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) pulses++;
        end
        check("abort/no_valid", pulses, 32'd0);

        launch(32'h0001_0000, 32'h0003_0000);
        track("after_abort", 32'h0000_5555, 1'b0, 1'b0, 48, 0, 0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_point_divider.md
FIXED_POINT_DIVIDER -- requirements
Module: fixed_point_divider

Interface
REQ-001 SHALL have parameter sign, default 1, meaning sign bit count (sign-magnitude format).
REQ-002 SHALL have parameter q_m, default 15, meaning integer magnitude bits.
REQ-003 SHALL have parameter q_n, default 16, meaning fractional bits.
REQ-004 SHALL use W = sign+q_m+q_n (32 at defaults), M = W-1 magnitude bits, N = M+q_n iteration count (47 at defaults).
REQ-005 SHALL have clk_in, input, 1, the single clock; all state changes on rising edge.
REQ-006 SHALL have rst_n_in, input, 1, synchronous active-low reset.
REQ-007 SHALL have start_in, input, 1, request a division; sampled only while idle.
REQ-008 SHALL have a_in, input, W, dividend, sign-magnitude Qq_m.q_n, bit W-1 is sign.
REQ-009 SHALL have b_in, input, W, divisor, same format.
REQ-010 SHALL have y_out, output, W, quotient, same format.
REQ-011 SHALL have valid_out, output, 1, one-cycle pulse marking a new y_out.
REQ-012 SHALL have busy_out, output, 1, high while a division is in progress.
REQ-013 SHALL have div_by_zero_out, output, 1, flag for the current y_out.
REQ-014 SHALL have overflow_out, output, 1, flag for the current y_out.

Function
REQ-015 SHALL compute magnitude |y| = floor((|a| << q_n) / |b|) with restoring division, one quotient bit per clock, MSB first.
REQ-016 SHALL set y_out sign bit = a_in[W-1] XOR b_in[W-1] captured at start, including when the magnitude is zero.
REQ-017 SHALL capture a_in and b_in at the start edge; later input changes have no effect on the operation in progress.
REQ-018 SHALL implement states IDLE, DIVIDE, DONE; IDLE->DIVIDE on start_in=1 with |b|!=0, loading counter = N-1.
REQ-019 SHALL, in DIVIDE, produce one quotient bit per edge and go to DONE on the edge where counter = 0 (N DIVIDE edges).
REQ-020 SHALL go IDLE->DONE directly on start_in=1 with |b|=0 (both +0 and -0 divisors).
REQ-021 SHALL, in DONE, register y_out and flags, drive valid_out=1 for that one cycle, and return to IDLE.
REQ-022 SHALL give latency: start sampled at edge 0 -> valid_out high from edge N+1 to edge N+2 (48 to 49 at defaults); divide-by-zero: high from edge 1 to edge 2.
REQ-023 SHALL drive busy_out=1 whenever state != IDLE; busy_out falls on the same edge valid_out rises.
REQ-024 SHALL ignore start_in while busy_out=1; SHALL accept start_in in the valid_out cycle (back-to-back).
REQ-025 SHALL, on divide-by-zero, output magnitude all-ones, div_by_zero_out=1, overflow_out=0.
REQ-026 SHALL, when any N-bit quotient bit above bit M-1 is 1, saturate magnitude to all-ones with overflow_out=1.
REQ-027 SHALL otherwise output the low M quotient bits truncated (no rounding) with both flags 0.
REQ-028 SHALL hold y_out and flags stable until the next DONE cycle.

Reset
REQ-029 SHALL, with rst_n_in=0 at an edge, force state IDLE, y_out=0, valid_out=0, busy_out=0, div_by_zero_out=0, overflow_out=0, counter=0.
REQ-030 SHALL, on reset mid-operation, abort without producing valid_out; the first start after release behaves normally.
REQ-031 SHALL give reset priority over start_in on the same edge.

Verification
REQ-032 SHALL check a=0x00060000 (6.0), b=0x00020000 (2.0) -> y=0x00030000, flags 0, valid high from edge 48 to 49 only.
REQ-033 SHALL check a=0x80018000 (-1.5), b=0x00008000 (0.5) -> y=0x80030000 (-3.0); and a=0x00010000, b=0x00030000 -> y=0x00005555.
REQ-034 SHALL check a=0x00010000, b=0x80000000 (-0) -> y=0xFFFFFFFF, div_by_zero_out=1, valid high from edge 1 to 2.
REQ-035 SHALL check a=0x7FFF0000, b=0x00000001 -> y=0x7FFFFFFF, overflow_out=1.
REQ-036 SHALL check start pulses at edges 10 and 30 of a division -> both ignored; start held in the valid_out cycle -> second result 48 edges later.
REQ-037 SHALL check rst_n_in low at edge 20 of a division -> all outputs 0, no valid_out; the next division returns the correct result.
